// File: rtl/ahb_cache_arbiter_if.sv
// AHB-Lite master-side signal bundle shared by the cache arbiter and the bus it drives.
// Latency: none, wires only.
// Backpressure: HREADY from the slave side stalls the master; no other flow control.
interface ahb_cache_arbiter_if;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_cache_arbiter.sv
// Arbitrates I-cache refill and D-cache refill/write-back/uncached traffic onto one AHB-Lite master port.
// Latency: request to NONSEQ 1 cycle; rvalid 1 cycle after each read data phase; done 1 cycle after the last data phase.
// Backpressure: HREADY low holds every bus output; requesters hold req until done, D write beats advance on d_wdata_ack.
module ahb_cache_arbiter #(
    parameter int LINE_WORDS = 8,
    parameter bit FAIR       = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_burst,
    output logic [31:0] i_rdata,
    output logic        i_rvalid,
    output logic        i_done,
    output logic        i_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_write,
    input  logic        d_burst,
    input  logic [31:0] d_wdata,
    output logic        d_wdata_ack,
    output logic [31:0] d_rdata,
    output logic        d_rvalid,
    output logic        d_done,
    output logic        d_err,
    ahb_cache_arbiter_if.master ahb
);
    localparam int         CW          = $clog2(LINE_WORDS) + 1;
    localparam logic [2:0] HBURST_LINE = (LINE_WORDS == 4) ? 3'b011 : 3'b101;
    localparam logic [1:0] HT_IDLE     = 2'b00;
    localparam logic [1:0] HT_NONSEQ   = 2'b10;
    localparam logic [1:0] HT_SEQ      = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t          state_q, state_d;
    logic            own_d_q, own_d_d;      // current owner, doubles as last-grant
    logic            write_q, write_d;
    logic            burst_q, burst_d;
    logic [CW-1:0]   acnt_q, acnt_d;        // address beats accepted
    logic [CW-1:0]   dcnt_q, dcnt_d;        // data phases completed
    logic [31:0]     haddr_q, haddr_d;
    logic [31:0]     hwdata_q, hwdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [1:0]      htrans_q, htrans_d;
    logic [2:0]      hburst_q, hburst_d;
    logic [3:0]      hprot_q, hprot_d;
    logic            hwrite_q, hwrite_d;
    logic            rvalid_q, rvalid_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            pick_d;
    logic            data_pend;
    logic            addr_take;
    logic [CW-1:0]   last_beat;

    // With both pending, FAIR hands the grant to whoever did not have it last time.
    assign pick_d    = FAIR ? (d_req && (!i_req || !own_d_q)) : d_req;
    assign last_beat = burst_q ? CW'(LINE_WORDS - 1) : '0;
    // A data phase is outstanding whenever more addresses were accepted than data phases finished.
    assign data_pend = (acnt_q != dcnt_q);
    assign addr_take = (state_q == S_ADDR) && ahb.HREADY && !(data_pend && ahb.HRESP);

    // Next-state and next-value logic for the transaction sequencer and all registered outputs.
    always_comb begin
        state_d  = state_q;
        own_d_d  = own_d_q;
        write_d  = write_q;
        burst_d  = burst_q;
        acnt_d   = acnt_q;
        dcnt_d   = dcnt_q;
        haddr_d  = haddr_q;
        hwdata_d = hwdata_q;
        rdata_d  = rdata_q;
        htrans_d = htrans_q;
        hburst_d = hburst_q;
        hprot_d  = hprot_q;
        hwrite_d = hwrite_q;
        rvalid_d = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // The done cycle is skipped so the finishing owner's still-high req is not re-granted.
                if (!done_q && (i_req || d_req)) begin
                    own_d_d  = pick_d;
                    write_d  = pick_d && d_write;
                    burst_d  = pick_d ? d_burst : i_burst;
                    haddr_d  = pick_d ? d_addr : i_addr;
                    htrans_d = HT_NONSEQ;
                    hburst_d = burst_d ? HBURST_LINE : 3'b000;
                    hwrite_d = write_d;
                    hprot_d  = pick_d ? 4'b0011 : 4'b0010;
                    acnt_d   = '0;
                    dcnt_d   = '0;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                if (data_pend && ahb.HRESP) begin
                    htrans_d = HT_IDLE;
                    if (ahb.HREADY) begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = S_ERR2;
                    end else begin
                        state_d = S_ERR1;
                    end
                end else if (ahb.HREADY) begin
                    if (data_pend) begin
                        dcnt_d = dcnt_q + CW'(1);
                        if (!write_q) begin
                            rvalid_d = 1'b1;
                            rdata_d  = ahb.HRDATA;
                        end
                    end
                    acnt_d = acnt_q + CW'(1);
                    if (write_q) begin
                        hwdata_d = d_wdata;
                    end
                    if (acnt_q == last_beat) begin
                        htrans_d = HT_IDLE;
                        state_d  = S_DATA;
                    end else begin
                        htrans_d = HT_SEQ;
                        haddr_d  = haddr_q + 32'd4;
                    end
                end
            end
            S_DATA: begin
                if (ahb.HRESP) begin
                    if (ahb.HREADY) begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = S_ERR2;
                    end else begin
                        state_d = S_ERR1;
                    end
                end else if (ahb.HREADY) begin
                    dcnt_d = dcnt_q + CW'(1);
                    if (!write_q) begin
                        rvalid_d = 1'b1;
                        rdata_d  = ahb.HRDATA;
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ERR1: begin
                if (ahb.HREADY) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_ERR2;
                end
            end
            S_ERR2:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset abandons any transfer without a completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            own_d_q  <= 1'b0;
            write_q  <= 1'b0;
            burst_q  <= 1'b0;
            acnt_q   <= '0;
            dcnt_q   <= '0;
            haddr_q  <= '0;
            hwdata_q <= '0;
            rdata_q  <= '0;
            htrans_q <= HT_IDLE;
            hburst_q <= 3'b000;
            hprot_q  <= 4'b0011;
            hwrite_q <= 1'b0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            own_d_q  <= own_d_d;
            write_q  <= write_d;
            burst_q  <= burst_d;
            acnt_q   <= acnt_d;
            dcnt_q   <= dcnt_d;
            haddr_q  <= haddr_d;
            hwdata_q <= hwdata_d;
            rdata_q  <= rdata_d;
            htrans_q <= htrans_d;
            hburst_q <= hburst_d;
            hprot_q  <= hprot_d;
            hwrite_q <= hwrite_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign ahb.HADDR     = haddr_q;
    assign ahb.HBURST    = hburst_q;
    assign ahb.HMASTLOCK = 1'b0;
    assign ahb.HPROT     = hprot_q;
    assign ahb.HSIZE     = 3'b010;
    assign ahb.HTRANS    = htrans_q;
    assign ahb.HWDATA    = hwdata_q;
    assign ahb.HWRITE    = hwrite_q;

    // Only the owner sees read data and completion; the other side stays at zero.
    assign i_rdata     = own_d_q ? 32'd0 : rdata_q;
    assign i_rvalid    = rvalid_q && !own_d_q;
    assign i_done      = done_q && !own_d_q;
    assign i_err       = err_q && !own_d_q;
    assign d_rdata     = own_d_q ? rdata_q : 32'd0;
    assign d_rvalid    = rvalid_q && own_d_q;
    assign d_done      = done_q && own_d_q;
    assign d_err       = err_q && own_d_q;
    assign d_wdata_ack = addr_take && own_d_q && write_q && !reset;
endmodule

// File: tb/tb_ahb_cache_arbiter.sv
module tb_ahb_cache_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        i_req, i_burst, d_req, d_write, d_burst;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata;
    logic        i_rvalid, i_done, i_err, d_wdata_ack, d_rvalid, d_done, d_err;
    ahb_cache_arbiter_if bus0();

    ahb_cache_arbiter #(.LINE_WORDS(8), .FAIR(1'b1)) dut0 (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_burst(i_burst),
        .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done), .i_err(i_err),
        .d_req(d_req), .d_addr(d_addr), .d_write(d_write), .d_burst(d_burst),
        .d_wdata(d_wdata), .d_wdata_ack(d_wdata_ack),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done), .d_err(d_err),
        .ahb(bus0)
    );

    logic        i1_req, d1_req;
    logic [31:0] i1_rdata, d1_rdata;
    logic        i1_rvalid, i1_done, i1_err, d1_wdata_ack, d1_rvalid, d1_done, d1_err;
    ahb_cache_arbiter_if bus1();

    ahb_cache_arbiter #(.LINE_WORDS(4), .FAIR(1'b0)) dut1 (
        .clk(clk), .reset(reset),
        .i_req(i1_req), .i_addr(32'h0000_6000), .i_burst(1'b0),
        .i_rdata(i1_rdata), .i_rvalid(i1_rvalid), .i_done(i1_done), .i_err(i1_err),
        .d_req(d1_req), .d_addr(32'h0000_7000), .d_write(1'b0), .d_burst(1'b1),
        .d_wdata(32'h0), .d_wdata_ack(d1_wdata_ack),
        .d_rdata(d1_rdata), .d_rvalid(d1_rvalid), .d_done(d1_done), .d_err(d1_err),
        .ahb(bus1)
    );

    int vectors;
    int miscompares;

    logic [31:0] rd_base;
    logic [1:0]  tr_log [0:63];
    logic [31:0] addr_log [0:15];
    logic [31:0] rv_log [0:15];
    logic [31:0] wd_log [0:15];
    int          order [0:7];
    int          na, nrv, nwd, nack, nord, leak;
    int          done_cyc, last_rv_cyc, first_ns_cyc, err1_cyc;
    logic        done_err, ns_write;
    logic [2:0]  ns_burst;
    logic [3:0]  ns_prot;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Drives requesters and a small AHB slave on bus0 until every request has been dropped.
    task automatic run(input bit use_i, input bit use_d, input int d_again,
                       input int stall_beat, input int stall_n, input int err_beat, input bit rst_mid);
        bit dph, fin, rst_now, drop_i, drop_d, ack_seen;
        int dph_idx, acount, stall_left, err_stage, wk, again;
        na = 0; nrv = 0; nwd = 0; nack = 0; nord = 0; leak = 0;
        done_cyc = -1; last_rv_cyc = -1; first_ns_cyc = -1; err1_cyc = -1;
        done_err = 1'b0; ns_write = 1'b0; ns_burst = 3'b111; ns_prot = 4'hF;
        for (int k = 0; k < 64; k++) tr_log[k] = 2'b00;
        dph = 1'b0; fin = 1'b0; rst_now = 1'b0;
        dph_idx = 0; acount = 0; stall_left = stall_n; err_stage = 0; wk = 0; again = d_again;
        i_req = use_i; d_req = use_d; d_wdata = 32'hA0;
        for (int c = 0; c < 64 && !fin; c++) begin
            bus0.HREADY = 1'b1; bus0.HRESP = 1'b0; bus0.HRDATA = 32'h0;
            if (dph) begin
                bus0.HRDATA = rd_base + 32'(dph_idx);
                if (dph_idx == stall_beat && stall_left > 0) begin
                    bus0.HREADY = 1'b0;
                    stall_left--;
                end else if (dph_idx == err_beat) begin
                    bus0.HRESP  = 1'b1;
                    bus0.HREADY = (err_stage != 0);
                    if (err_stage == 0) err1_cyc = c;
                    err_stage++;
                end
            end
            @(negedge clk);
            tr_log[c] = bus0.HTRANS;
            if (bus0.HTRANS[1] && first_ns_cyc < 0) begin
                first_ns_cyc = c; ns_burst = bus0.HBURST; ns_prot = bus0.HPROT; ns_write = bus0.HWRITE;
            end
            if (bus0.HTRANS[1] && bus0.HREADY && na < 16) begin addr_log[na] = bus0.HADDR; na++; end
            if (dph && bus0.HREADY && use_d && d_write && nwd < 16) begin wd_log[nwd] = bus0.HWDATA; nwd++; end
            if (bus0.HREADY) begin
                dph = bus0.HTRANS[1];
                if (bus0.HTRANS[1]) begin dph_idx = acount; acount++; end
            end
            if (!use_i && (i_rvalid || i_done || i_err)) leak++;
            if ((!use_d || !d_write) && d_wdata_ack) leak++;
            if (!use_d && (d_rvalid || d_done || d_err)) leak++;
            ack_seen = d_wdata_ack;
            if (ack_seen) nack++;
            if ((i_rvalid || d_rvalid) && nrv < 16) begin
                rv_log[nrv] = i_rvalid ? i_rdata : d_rdata; nrv++; last_rv_cyc = c;
            end
            drop_i = 1'b0; drop_d = 1'b0;
            if (i_done) begin order[nord] = 0; nord++; done_cyc = c; done_err = i_err; drop_i = 1'b1; end
            if (d_done) begin
                order[nord] = 1; nord++; done_cyc = c; done_err = d_err;
                if (again > 0) again--; else drop_d = 1'b1;
            end
            if (rst_mid && bus0.HTRANS[1] && bus0.HADDR == d_addr + 32'h10) begin
                reset = 1'b1; i_req = 1'b0; d_req = 1'b0; rst_now = 1'b1;
            end
            @(posedge clk);
            #1;
            if (rst_now) reset = 1'b0;
            if (ack_seen) begin wk++; d_wdata = 32'hA0 + 32'(wk); end
            if (drop_i) i_req = 1'b0;
            if (drop_d) d_req = 1'b0;
            if (!i_req && !d_req) fin = 1'b1;
        end
        check("run_finished", {31'b0, fin}, 32'd1);
    endtask

    initial begin
        int rep;
        int ord1 [0:3];
        int n1, nacc1;
        logic [2:0] burst1;
        vectors = 0; miscompares = 0;
        reset = 1'b1;
        i_req = 1'b0; d_req = 1'b0; i_burst = 1'b0; d_burst = 1'b0; d_write = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; rd_base = 32'h0;
        bus0.HREADY = 1'b1; bus0.HRESP = 1'b0; bus0.HRDATA = 32'h0;
        i1_req = 1'b0; d1_req = 1'b0;
        bus1.HREADY = 1'b1; bus1.HRESP = 1'b0; bus1.HRDATA = 32'h1111_0000;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_htrans", {30'b0, bus0.HTRANS}, 32'd0);
        check("rst_haddr", bus0.HADDR, 32'd0);
        check("rst_hburst_hwrite", {28'b0, bus0.HBURST, bus0.HWRITE}, 32'd0);
        check("rst_hwdata", bus0.HWDATA, 32'd0);
        check("rst_hsize", {29'b0, bus0.HSIZE}, 32'd2);
        check("rst_hprot", {28'b0, bus0.HPROT}, 32'h3);
        check("rst_hmastlock", {31'b0, bus0.HMASTLOCK}, 32'd0);
        check("rst_rdata", i_rdata | d_rdata, 32'd0);
        check("rst_flags", {25'b0, i_rvalid, i_done, i_err, d_rvalid, d_done, d_err, d_wdata_ack}, 32'd0);
        @(posedge clk); #1;

        // D single read
        d_addr = 32'h1000; d_write = 1'b0; d_burst = 1'b0; rd_base = 32'hDEADBEEF;
        run(1'b0, 1'b1, 0, -1, 0, -1, 1'b0);
        check("t1_nonseq_cycle", 32'(first_ns_cyc), 32'd1);
        check("t1_hburst", {29'b0, ns_burst}, 32'd0);
        check("t1_hprot", {28'b0, ns_prot}, 32'h3);
        check("t1_addr", addr_log[0], 32'h1000);
        check("t1_htrans_idle_t2", {30'b0, tr_log[2]}, 32'd0);
        check("t1_done_cycle", 32'(done_cyc), 32'd3);
        check("t1_rvalid_cycle", 32'(last_rv_cyc), 32'd3);
        check("t1_rdata", rv_log[0], 32'hDEADBEEF);
        check("t1_err", {31'b0, done_err}, 32'd0);
        check("t1_leak", 32'(leak), 32'd0);

        // I line read with a 2-cycle stall on beat 3
        i_addr = 32'h2000; i_burst = 1'b1; rd_base = 32'h1000_0000;
        run(1'b1, 1'b0, 0, 3, 2, -1, 1'b0);
        check("t2_hburst", {29'b0, ns_burst}, 32'h5);
        check("t2_hprot", {28'b0, ns_prot}, 32'h2);
        check("t2_nbeats", 32'(na), 32'd8);
        for (int k = 0; k < 8; k++) check("t2_haddr", addr_log[k], 32'h2000 + 32'(4 * k));
        check("t2_nrvalid", 32'(nrv), 32'd8);
        for (int k = 0; k < 8; k++) check("t2_rdata", rv_log[k], 32'h1000_0000 + 32'(k));
        check("t2_done_with_last", 32'(done_cyc), 32'(last_rv_cyc));
        check("t2_err", {31'b0, done_err}, 32'd0);
        check("t2_leak", 32'(leak), 32'd0);

        // D write burst
        d_addr = 32'h3000; d_write = 1'b1; d_burst = 1'b1;
        run(1'b0, 1'b1, 0, -1, 0, -1, 1'b0);
        check("t4_hwrite", {31'b0, ns_write}, 32'd1);
        check("t4_acks", 32'(nack), 32'd8);
        check("t4_nwdata", 32'(nwd), 32'd8);
        for (int k = 0; k < 8; k++) check("t4_hwdata", wd_log[k], 32'hA0 + 32'(k));
        check("t4_last_addr", addr_log[7], 32'h301C);
        check("t4_no_rvalid", 32'(nrv), 32'd0);
        check("t4_err", {31'b0, done_err}, 32'd0);
        check("t4_leak", 32'(leak), 32'd0);

        // I burst with a two-cycle ERROR on beat 2
        i_addr = 32'h2400; i_burst = 1'b1; rd_base = 32'h2000_0000;
        run(1'b1, 1'b0, 0, -1, 0, 2, 1'b0);
        check("t5_nrvalid", 32'(nrv), 32'd2);
        check("t5_err1_cycle", 32'(err1_cyc), 32'd4);
        check("t5_htrans_idle", {30'b0, tr_log[5]}, 32'd0);
        check("t5_beats_taken", 32'(na), 32'd3);
        check("t5_done_cycle", 32'(done_cyc), 32'd6);
        check("t5_err", {31'b0, done_err}, 32'd1);
        check("t5_leak", 32'(leak), 32'd0);

        // Contention after reset, FAIR=1: D, I, then D again
        do_reset();
        d_write = 1'b0; d_burst = 1'b0; i_burst = 1'b0; d_addr = 32'h1100; i_addr = 32'h2100;
        run(1'b1, 1'b1, 1, -1, 0, -1, 1'b0);
        check("t3_ngrants", 32'(nord), 32'd3);
        check("t3_grant0", 32'(order[0]), 32'd1);
        check("t3_grant1", 32'(order[1]), 32'd0);
        check("t3_grant2", 32'(order[2]), 32'd1);

        // Reset during beat 4 of a D burst, then a fresh I request
        d_addr = 32'h5000; d_burst = 1'b1; rd_base = 32'h3000_0000;
        run(1'b0, 1'b1, 0, -1, 0, -1, 1'b1);
        check("t6_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
        @(negedge clk);
        check("t6_htrans_idle", {30'b0, bus0.HTRANS}, 32'd0);
        check("t6_d_flags", {29'b0, d_rvalid, d_done, d_err}, 32'd0);
        @(posedge clk); #1;
        i_addr = 32'h4000; i_burst = 1'b0; rd_base = 32'h55AA_0000;
        run(1'b1, 1'b0, 0, -1, 0, -1, 1'b0);
        check("t6_i_nonseq", 32'(first_ns_cyc), 32'd1);
        check("t6_i_addr", addr_log[0], 32'h4000);
        check("t6_i_rdata", rv_log[0], 32'h55AA_0000);
        check("t6_i_done", 32'(done_cyc), 32'd3);

        // FAIR=0, LINE_WORDS=4: D wins every contention
        i1_req = 1'b1; d1_req = 1'b1; rep = 1; n1 = 0; nacc1 = 0; burst1 = 3'b111;
        for (int c = 0; c < 100 && (i1_req || d1_req); c++) begin
            bit di, dd;
            @(negedge clk);
            di = 1'b0; dd = 1'b0;
            if (bus1.HTRANS == 2'b10 && burst1 == 3'b111) burst1 = bus1.HBURST;
            if (bus1.HTRANS[1] && bus1.HREADY) nacc1++;
            if (d1_done && n1 < 4) begin
                ord1[n1] = 1; n1++;
                if (rep > 0) rep--; else dd = 1'b1;
            end
            if (i1_done && n1 < 4) begin ord1[n1] = 0; n1++; di = 1'b1; end
            @(posedge clk); #1;
            if (di) i1_req = 1'b0;
            if (dd) d1_req = 1'b0;
        end
        check("f0_finished", {30'b0, i1_req, d1_req}, 32'd0);
        check("f0_ngrants", 32'(n1), 32'd3);
        check("f0_grant0", 32'(ord1[0]), 32'd1);
        check("f0_grant1", 32'(ord1[1]), 32'd1);
        check("f0_grant2", 32'(ord1[2]), 32'd0);
        check("f0_hburst_incr4", {29'b0, burst1}, 32'h3);
        check("f0_beats", 32'(nacc1), 32'd9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
